// File: rtl/mem_stage_dmem.sv
// MEM-stage data memory: byte-addressable little-endian RAM with byte/half/word
// stores and registered, sign- or zero-extended loads.
module mem_stage_dmem #(
  parameter int NB_WIDTH = 32,
  parameter int NB_ADDR  = 9,
  parameter int NB_DATA  = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NB_WIDTH-1:0] i_mem_addr,
  input  logic [NB_WIDTH-1:0] i_mem_data,
  input  logic                i_mem_read_CU,
  input  logic                i_mem_write_CU,
  input  logic [2:0]          i_BHW_CU,
  output logic [NB_WIDTH-1:0] o_read_data
);

  localparam int DEPTH = 1 << NB_ADDR;

  logic [NB_DATA-1:0]  mem [DEPTH];
  logic [NB_ADDR-1:0]  a0, a1, a2, a3;
  logic [1:0]          size;
  logic                load_unsigned;
  logic [NB_DATA-1:0]  raw_byte;
  logic [2*NB_DATA-1:0] raw_half;
  logic [4*NB_DATA-1:0] raw_word;
  logic [NB_WIDTH-1:0] load_ext;
  logic                unused_addr_bits;

  // Upper address bits are ignored; lane addresses wrap through the truncated add.
  assign unused_addr_bits = ^i_mem_addr[NB_WIDTH-1:NB_ADDR];
  assign a0            = i_mem_addr[NB_ADDR-1:0];
  assign a1            = a0 + NB_ADDR'(1);
  assign a2            = a0 + NB_ADDR'(2);
  assign a3            = a0 + NB_ADDR'(3);
  assign size          = i_BHW_CU[1:0];
  assign load_unsigned = i_BHW_CU[2];

  assign raw_byte = mem[a0];
  assign raw_half = {mem[a1], mem[a0]};
  assign raw_word = {mem[a3], mem[a2], mem[a1], mem[a0]};

  always_comb begin
    load_ext = raw_word;
    case (size)
      2'b00: begin
        if (load_unsigned) load_ext = {{(NB_WIDTH-NB_DATA){1'b0}}, raw_byte};
        else               load_ext = {{(NB_WIDTH-NB_DATA){raw_byte[NB_DATA-1]}}, raw_byte};
      end
      2'b01: begin
        if (load_unsigned) load_ext = {{(NB_WIDTH-2*NB_DATA){1'b0}}, raw_half};
        else               load_ext = {{(NB_WIDTH-2*NB_DATA){raw_half[2*NB_DATA-1]}}, raw_half};
      end
      default: load_ext = raw_word;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (i_mem_write_CU) begin
      mem[a0] <= i_mem_data[NB_DATA-1:0];
      if (size != 2'b00) mem[a1] <= i_mem_data[2*NB_DATA-1:NB_DATA];
      if (size[1]) begin
        mem[a2] <= i_mem_data[3*NB_DATA-1:2*NB_DATA];
        mem[a3] <= i_mem_data[4*NB_DATA-1:3*NB_DATA];
      end
    end
  end

  // Load samples the array before this edge's store lands: read-before-write.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)           o_read_data <= '0;
    else if (i_mem_read_CU) o_read_data <= load_ext;
  end

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Directed plus randomized bench for mem_stage_dmem against a byte-array model.
module tb_mem_stage_dmem;

  logic        i_clk;
  logic        i_reset;
  logic [31:0] i_mem_addr;
  logic [31:0] i_mem_data;
  logic        i_mem_read_CU;
  logic        i_mem_write_CU;
  logic [2:0]  i_BHW_CU;
  logic [31:0] o_read_data;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_mem [512];
  logic [31:0] exp_rd;

  mem_stage_dmem dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_mem_addr     (i_mem_addr),
    .i_mem_data     (i_mem_data),
    .i_mem_read_CU  (i_mem_read_CU),
    .i_mem_write_CU (i_mem_write_CU),
    .i_BHW_CU       (i_BHW_CU),
    .o_read_data    (o_read_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic int nbytes(input logic [2:0] code);
    if (code[1])      return 4;
    else if (code[0]) return 2;
    else              return 1;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] code);
    int a = int'(addr % 512);
    int n = nbytes(code);
    logic [31:0] v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_mem[(a + k) % 512]) << (8 * k));
    if (!code[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!code[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] code);
    int a = int'(addr % 512);
    int n = nbytes(code);
    for (int k = 0; k < n; k++) ref_mem[(a + k) % 512] = 8'((data >> (8 * k)) & 32'hFF);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
    exp_rd = 32'd0;
  endtask

  task automatic check(input string tag, input logic [31:0] expected);
    checks++;
    assert (o_read_data === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, o_read_data, expected);
      end
  endtask

  // One clock: drive, update model (load sees pre-store contents), compare output.
  task automatic step(input logic rd, input logic wr, input logic [2:0] code,
                      input logic [31:0] addr, input logic [31:0] data, input string tag);
    i_mem_read_CU  = rd;
    i_mem_write_CU = wr;
    i_BHW_CU       = code;
    i_mem_addr     = addr;
    i_mem_data     = data;
    @(posedge i_clk);
    #1;
    if (rd) exp_rd = model_load(addr, code);
    if (wr) model_store(addr, data, code);
    i_mem_read_CU  = 1'b0;
    i_mem_write_CU = 1'b0;
    check(tag, exp_rd);
  endtask

  task automatic store(input logic [2:0] code, input logic [31:0] addr, input logic [31:0] data);
    step(1'b0, 1'b1, code, addr, data, "store_hold");
  endtask

  task automatic load(input logic [2:0] code, input logic [31:0] addr, input string tag,
                      input logic [31:0] spec_val);
    step(1'b1, 1'b0, code, addr, 32'd0, tag);
    check({tag, "_spec"}, spec_val);
  endtask

  initial begin
    logic [31:0] addr, data;
    logic [2:0]  code;
    logic        rd, wr;

    model_clear();
    i_reset = 1'b0;
    i_mem_addr = '0; i_mem_data = '0;
    i_mem_read_CU = 1'b0; i_mem_write_CU = 1'b0; i_BHW_CU = 3'b000;
    @(posedge i_clk);
    #3;
    check("reset_rd", 32'd0);
    i_reset = 1'b1;
    #3;

    load(3'b011, 32'd0, "reset_word0", 32'h0000_0000);

    store(3'b000, 32'd4, 32'h0000_00FF);
    load(3'b000, 32'd4, "byte_signed", 32'hFFFF_FFFF);

    store(3'b001, 32'd8, 32'h0000_A5A5);
    load(3'b001, 32'd8, "half_signed", 32'hFFFF_A5A5);

    store(3'b011, 32'd12, 32'hDEAD_BEEF);
    load(3'b011, 32'd12, "word", 32'hDEAD_BEEF);
    load(3'b000, 32'd12, "byte12", 32'hFFFF_FFEF);
    load(3'b000, 32'd13, "byte13", 32'hFFFF_FFBE);
    load(3'b000, 32'd14, "byte14", 32'hFFFF_FFAD);
    load(3'b000, 32'd15, "byte15", 32'hFFFF_FFDE);

    store(3'b100, 32'd16, 32'h0F00_00FF);
    load(3'b100, 32'd16, "byte_unsigned", 32'h0000_00FF);
    load(3'b100, 32'd17, "byte17_untouched", 32'h0000_0000);

    store(3'b101, 32'd20, 32'h0000_FF00);
    load(3'b101, 32'd20, "half_unsigned", 32'h0000_FF00);

    store(3'b011, 32'd510, 32'h1122_3344);
    load(3'b100, 32'd510, "wrap510", 32'h0000_0044);
    load(3'b100, 32'd511, "wrap511", 32'h0000_0033);
    load(3'b100, 32'd0,   "wrap0",   32'h0000_0022);
    load(3'b100, 32'd1,   "wrap1",   32'h0000_0011);
    load(3'b010, 32'hFFFF_FFFE, "wrap_word_hiaddr", 32'h1122_3344);

    step(1'b1, 1'b1, 3'b011, 32'd12, 32'h1234_5678, "raw_old");
    check("raw_old_spec", 32'hDEAD_BEEF);
    load(3'b111, 32'd12, "raw_new", 32'h1234_5678);

    step(1'b0, 1'b0, 3'b000, 32'd4, 32'd0, "hold1");
    check("hold1_spec", 32'h1234_5678);
    step(1'b0, 1'b1, 3'b110, 32'd12, 32'hCAFE_F00D, "hold2");
    check("hold2_spec", 32'h1234_5678);

    for (int i = 0; i < 400; i++) begin
      code = 3'($urandom_range(0, 7));
      addr = ($urandom & 32'hFFFF_FE00) |
             (($urandom_range(0, 3) == 0) ? 32'($urandom_range(500, 511)) : 32'($urandom_range(0, 47)));
      data = $urandom;
      rd   = 1'($urandom_range(0, 2) != 0);
      wr   = 1'($urandom_range(0, 1));
      step(rd, wr, code, addr, data, "random");
    end

    // Reset asserted mid-cycle while a store and load are pending.
    i_mem_read_CU = 1'b1; i_mem_write_CU = 1'b1; i_BHW_CU = 3'b011;
    i_mem_addr = 32'd12; i_mem_data = 32'hA5A5_5A5A;
    #2;
    i_reset = 1'b0;
    #1;
    model_clear();
    check("async_reset", 32'd0);
    @(posedge i_clk);
    #1;
    check("reset_held", 32'd0);
    i_mem_read_CU = 1'b0; i_mem_write_CU = 1'b0;
    #2;
    i_reset = 1'b1;
    #2;
    load(3'b011, 32'd12, "post_reset12", 32'h0000_0000);
    load(3'b011, 32'd510, "post_reset510", 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
